memarb: RTL and testbench
=========================

MEMARB -- requirements
Module: memarb

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 = round-robin on contention, 1 = port 0 always wins contention.
REQ-002 Parameter LOCK_TIMEOUT, default 16, legal 1..255; idle cycles tolerated while a lock is held before forced release.
REQ-003 clk  in  1  sole clock, all state updates on posedge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 pN_req  in  1  (N = 0, 1) access request; held high until pN_ack.
REQ-006 pN_we  in  1  1 = write, 0 = read.
REQ-007 pN_addr  in  16  word address.
REQ-008 pN_wdata  in  16  write data.
REQ-009 pN_lock  in  1  keep ownership after this access.
REQ-010 pN_ack  out  1  access issued to RAM this cycle.
REQ-011 pN_rvalid  out  1  read data valid on pN_rdata this cycle.
REQ-012 pN_rdata  out  16  read data; 0 when pN_rvalid = 0.
REQ-013 mem_waddr, mem_wdata  out  16 each  RAM write address and data.
REQ-014 mem_we  out  1  RAM write strobe.
REQ-015 mem_raddr  out  16  RAM read address.
REQ-016 mem_re  out  1  RAM read strobe.
REQ-017 mem_rdata  in  16  RAM read data, valid the cycle after mem_re.

Function
REQ-018 At most one access SHALL be issued per cycle; the winner, pN_ack, and mem_* SHALL be combinational from current inputs and registered state.
REQ-019 For the winner: mem_waddr = mem_raddr = pN_addr, mem_wdata = pN_wdata, mem_we = pN_we, mem_re = ~pN_we; with no winner, all mem_* outputs are 0.
REQ-020 pN_ack SHALL be high exactly in the cycle the access of port N is issued.
REQ-021 A read issued in cycle T SHALL produce pN_rvalid = 1 and pN_rdata = mem_rdata in cycle T+1 only; the other port's rvalid stays 0.
REQ-022 States: IDLE (no owner), OWN0, OWN1.
REQ-023 IDLE, single requester: that port wins.
REQ-024 IDLE, both requesting: FIXED_PRIO = 1 -> port 0 wins; FIXED_PRIO = 0 -> the port not in register last_grant wins.
REQ-025 last_grant SHALL update to the winner on every issued access.
REQ-026 IDLE -> OWNn when port n wins with pn_lock = 1.
REQ-027 In OWNn only port n SHALL be granted; the other port's requests are stalled (no ack).
REQ-028 OWNn -> IDLE when port n issues an access with pn_lock = 0, or when it has pn_req = 0 and pn_lock = 0 in some cycle.
REQ-029 In OWNn, a cycle with pn_req = 0 and pn_lock = 1 SHALL increment an 8-bit idle counter; an issued access SHALL clear it.
REQ-030 When the idle counter reaches LOCK_TIMEOUT, the block SHALL force OWNn -> IDLE on the next edge and clear the counter; the other port may win in that following cycle.
REQ-031 The idle counter SHALL be 0 whenever the state is IDLE and SHALL NOT wrap.
REQ-032 A read in the last cycle of ownership still returns rvalid in the next cycle, independent of the new grant.
REQ-033 Back-to-back accesses from one port SHALL be issued on consecutive cycles with no bubble.

Reset
REQ-034 While rst_n = 0 at posedge: state = IDLE, last_grant = 1, idle counter = 0, rvalid registers = 0; pN_ack, pN_rvalid, pN_rdata and all mem_* outputs SHALL read 0 during reset.
REQ-035 Reset asserted with a read issued SHALL suppress the following rvalid; a lock held at reset is dropped.

Verification
REQ-036 Both ports read continuously after reset, FIXED_PRIO = 0 -> acks alternate p0, p1, p0, ...; each rvalid arrives one cycle after its ack, with mem_rdata routed to the matching port.
REQ-037 FIXED_PRIO = 1, both ports requesting for 5 cycles -> p0_ack high all 5 cycles, p1_ack never high.
REQ-038 p0 writes 0xBEEF to 0x0010 with lock = 1, then reads 0x0010 with lock = 0 while p1 requests throughout -> p1 is stalled 2 cycles, then acked; p0 reads 0xBEEF.
REQ-039 p0 takes the lock and then idles with lock = 1, LOCK_TIMEOUT = 4, while p1 requests -> p1_ack rises exactly 5 cycles after p0's last ack.
REQ-040 p1 read acked, rst_n low in the next cycle -> p1_rvalid stays 0, and the first contention after reset grants p0.

Source files
------------

// File: rtl/memarb_if.sv
// Two-port requester bus plus the single-port RAM side of the memory arbiter.
// The arbiter uses the slave view; requesters and the RAM model use the master view.
interface memarb_if;
   logic        p0_req;
   logic        p0_we;
   logic        p0_lock;
   logic [15:0] p0_addr;
   logic [15:0] p0_wdata;
   logic        p0_ack;
   logic        p0_rvalid;
   logic [15:0] p0_rdata;
   logic        p1_req;
   logic        p1_we;
   logic        p1_lock;
   logic [15:0] p1_addr;
   logic [15:0] p1_wdata;
   logic        p1_ack;
   logic        p1_rvalid;
   logic [15:0] p1_rdata;
   logic [15:0] mem_waddr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] mem_raddr;
   logic        mem_re;
   logic [15:0] mem_rdata;

   modport slave (
      input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
      output p0_ack, p0_rvalid, p0_rdata,
      input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
      output p1_ack, p1_rvalid, p1_rdata,
      output mem_waddr, mem_wdata, mem_we, mem_raddr, mem_re,
      input  mem_rdata
   );

   modport master (
      output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
      input  p0_ack, p0_rvalid, p0_rdata,
      output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
      input  p1_ack, p1_rvalid, p1_rdata,
      input  mem_waddr, mem_wdata, mem_we, mem_raddr, mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/memarb.sv
// Two-port RAM arbiter: round-robin or fixed priority, with per-port
// bus locking and an idle timeout that forces a held lock to release.
module memarb #(
   parameter bit          FIXED_PRIO   = 1'b0,
   parameter int unsigned LOCK_TIMEOUT = 16
) (
   input logic     clk,
   input logic     rst_n,
   memarb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [7:0] TO_LAST = 8'(LOCK_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic       last_grant, last_nxt;
   logic [7:0] idle_cnt, idle_nxt;
   logic       rv0, rv1;
   logic       g0, g1;
   logic       own_lock;

   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.p0_req && bus.p1_req) begin
               g0 = FIXED_PRIO || last_grant;
               g1 = !(FIXED_PRIO || last_grant);
            end else begin
               g0 = bus.p0_req;
               g1 = bus.p1_req;
            end
         end
         OWN0: g0 = bus.p0_req;
         OWN1: g1 = bus.p1_req;
         default: ;
      endcase
      if (!rst_n) begin
         g0 = 1'b0;
         g1 = 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last_grant;
      idle_nxt  = idle_cnt;
      own_lock  = (state == OWN1) ? bus.p1_lock : bus.p0_lock;
      if (g0 || g1) begin
         last_nxt = g1;
         idle_nxt = 8'd0;
         if (g0)
            state_nxt = bus.p0_lock ? OWN0 : IDLE;
         else
            state_nxt = bus.p1_lock ? OWN1 : IDLE;
      end else if (state != IDLE) begin
         // Owner is idle here; release on unlock or after the idle budget.
         if (!own_lock || idle_cnt >= TO_LAST) begin
            state_nxt = IDLE;
            idle_nxt  = 8'd0;
         end else begin
            idle_nxt = idle_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         idle_cnt   <= 8'd0;
         rv0        <= 1'b0;
         rv1        <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_nxt;
         idle_cnt   <= idle_nxt;
         rv0        <= g0 & ~bus.p0_we;
         rv1        <= g1 & ~bus.p1_we;
      end
   end

   assign bus.p0_ack    = g0;
   assign bus.p1_ack    = g1;
   assign bus.p0_rvalid = rv0 & rst_n;
   assign bus.p1_rvalid = rv1 & rst_n;
   assign bus.p0_rdata  = (rv0 & rst_n) ? bus.mem_rdata : 16'h0000;
   assign bus.p1_rdata  = (rv1 & rst_n) ? bus.mem_rdata : 16'h0000;

   always_comb begin
      bus.mem_waddr = 16'h0000;
      bus.mem_raddr = 16'h0000;
      bus.mem_wdata = 16'h0000;
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      unique case (1'b1)
         g0: begin
            bus.mem_waddr = bus.p0_addr;
            bus.mem_raddr = bus.p0_addr;
            bus.mem_wdata = bus.p0_wdata;
            bus.mem_we    = bus.p0_we;
            bus.mem_re    = ~bus.p0_we;
         end
         g1: begin
            bus.mem_waddr = bus.p1_addr;
            bus.mem_raddr = bus.p1_addr;
            bus.mem_wdata = bus.p1_wdata;
            bus.mem_we    = bus.p1_we;
            bus.mem_re    = ~bus.p1_we;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_memarb.sv
// Bench for memarb: a round-robin/timeout-4 instance and a fixed-priority
// instance share stimulus and are each checked against a behavioural model.
module tb_memarb;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        req [2];
   logic        we  [2];
   logic        lk  [2];
   logic [15:0] ad  [2];
   logic [15:0] wd  [2];
   logic [15:0] mrd [2];

   memarb_if b0 ();
   memarb_if b1 ();

   assign b0.p0_req = req[0];
   assign b0.p0_we = we[0];
   assign b0.p0_lock = lk[0];
   assign b0.p0_addr = ad[0];
   assign b0.p0_wdata = wd[0];
   assign b0.p1_req = req[1];
   assign b0.p1_we = we[1];
   assign b0.p1_lock = lk[1];
   assign b0.p1_addr = ad[1];
   assign b0.p1_wdata = wd[1];
   assign b0.mem_rdata = mrd[0];
   assign b1.p0_req = req[0];
   assign b1.p0_we = we[0];
   assign b1.p0_lock = lk[0];
   assign b1.p0_addr = ad[0];
   assign b1.p0_wdata = wd[0];
   assign b1.p1_req = req[1];
   assign b1.p1_we = we[1];
   assign b1.p1_lock = lk[1];
   assign b1.p1_addr = ad[1];
   assign b1.p1_wdata = wd[1];
   assign b1.mem_rdata = mrd[1];

   memarb #(.FIXED_PRIO(1'b0), .LOCK_TIMEOUT(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0)
   );
   memarb #(.FIXED_PRIO(1'b1), .LOCK_TIMEOUT(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1)
   );

   logic [5:0]  flg  [2];
   logic [15:0] ord0 [2];
   logic [15:0] ord1 [2];
   logic [15:0] owa  [2];
   logic [15:0] ora  [2];
   logic [15:0] owd  [2];

   assign flg[0] = {b0.p0_ack, b0.p1_ack, b0.p0_rvalid,
                    b0.p1_rvalid, b0.mem_we, b0.mem_re};
   assign flg[1] = {b1.p0_ack, b1.p1_ack, b1.p0_rvalid,
                    b1.p1_rvalid, b1.mem_we, b1.mem_re};
   assign ord0[0] = b0.p0_rdata;
   assign ord1[0] = b0.p1_rdata;
   assign owa[0] = b0.mem_waddr;
   assign ora[0] = b0.mem_raddr;
   assign owd[0] = b0.mem_wdata;
   assign ord0[1] = b1.p0_rdata;
   assign ord1[1] = b1.p1_rdata;
   assign owa[1] = b1.mem_waddr;
   assign ora[1] = b1.mem_raddr;
   assign owd[1] = b1.mem_wdata;

   int total = 0;
   int bad = 0;

   // model: owner (-1 = none), last winner, idle cycles, pending read port
   int own [2] = '{-1, -1};
   int lastg [2] = '{1, 1};
   int idl [2] = '{0, 0};
   int pend [2] = '{-1, -1};
   int tmo [2] = '{4, 16};
   bit fp [2] = '{1'b0, 1'b1};
   logic [15:0] ram [int];

   logic [5:0]  sflg [2];
   logic [15:0] srd0 [2];
   logic [15:0] srd1 [2];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(int k);
      if (!rst_n) return -1;
      if (own[k] >= 0) return req[own[k]] ? own[k] : -1;
      if (req[0] && req[1]) return fp[k] ? 0 : (lastg[k] == 0 ? 1 : 0);
      if (req[0]) return 0;
      if (req[1]) return 1;
      return -1;
   endfunction

   function automatic logic [15:0] ramrd(int k, logic [15:0] a);
      int key = (k << 16) | int'(a);
      return ram.exists(key) ? ram[key] : 16'h0000;
   endfunction

   task automatic cyc();
      int w [2];
      logic [5:0] ef;
      logic [15:0] ea, ewd;
      logic [15:0] nrd [2];
      bit v0, v1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         w[k] = winner(k);
         v0 = rst_n && pend[k] == 0;
         v1 = rst_n && pend[k] == 1;
         ea = 16'h0000;
         ewd = 16'h0000;
         ef = {w[k] == 0, w[k] == 1, v0, v1, 2'b00};
         if (w[k] >= 0) begin
            ea = ad[w[k]];
            ewd = wd[w[k]];
            ef[1:0] = we[w[k]] ? 2'b10 : 2'b01;
         end
         chk($sformatf("d%0d_flags", k), 32'(flg[k]), 32'(ef));
         chk($sformatf("d%0d_waddr", k), 32'(owa[k]), 32'(ea));
         chk($sformatf("d%0d_raddr", k), 32'(ora[k]), 32'(ea));
         chk($sformatf("d%0d_wdata", k), 32'(owd[k]), 32'(ewd));
         chk($sformatf("d%0d_rdata0", k), 32'(ord0[k]),
             32'(v0 ? mrd[k] : 16'h0000));
         chk($sformatf("d%0d_rdata1", k), 32'(ord1[k]),
             32'(v1 ? mrd[k] : 16'h0000));
         sflg[k] = flg[k];
         srd0[k] = ord0[k];
         srd1[k] = ord1[k];
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         nrd[k] = 16'($urandom);
         if (!rst_n) begin
            own[k] = -1;
            lastg[k] = 1;
            idl[k] = 0;
            pend[k] = -1;
         end else begin
            pend[k] = -1;
            if (w[k] >= 0) begin
               lastg[k] = w[k];
               idl[k] = 0;
               own[k] = lk[w[k]] ? w[k] : -1;
               if (we[w[k]]) ram[(k << 16) | int'(ad[w[k]])] = wd[w[k]];
               else begin
                  pend[k] = w[k];
                  nrd[k] = ramrd(k, ad[w[k]]);
               end
            end else if (own[k] >= 0) begin
               if (!lk[own[k]]) begin
                  own[k] = -1;
                  idl[k] = 0;
               end else begin
                  idl[k]++;
                  if (idl[k] >= tmo[k]) begin
                     own[k] = -1;
                     idl[k] = 0;
                  end
               end
            end
         end
      end
      #1;
      mrd[0] = nrd[0];
      mrd[1] = nrd[1];
   endtask

   task automatic setp(int p, bit r, bit w, logic [15:0] a,
                       logic [15:0] d, bit l);
      req[p] = r;
      we[p] = w;
      ad[p] = a;
      wd[p] = d;
      lk[p] = l;
   endtask

   initial begin
      rst_n = 1'b0;
      mrd[0] = 16'h0000;
      mrd[1] = 16'h0000;
      setp(0, 0, 0, 0, 0, 0);
      setp(1, 0, 0, 0, 0, 0);
      cyc();
      cyc();
      // requests during reset must be ignored
      setp(0, 1, 0, 16'h0001, 0, 1);
      setp(1, 1, 1, 16'h0002, 0, 1);
      cyc();
      chk("rst_flags", 32'(sflg[0]), 32'd0);
      rst_n = 1'b1;

      setp(0, 1, 0, 16'h0003, 0, 0);
      setp(1, 1, 0, 16'h0007, 0, 0);
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("rr_ack0", 32'(sflg[0][5]), 32'(i % 2 == 0));
         chk("rr_ack1", 32'(sflg[0][4]), 32'(i % 2 == 1));
         if (i > 0) begin
            chk("rr_rv0", 32'(sflg[0][3]), 32'(i % 2 == 1));
            chk("rr_rv1", 32'(sflg[0][2]), 32'(i % 2 == 0));
         end
         chk("fix_ack0", 32'(sflg[1][5]), 32'd1);
         chk("fix_ack1", 32'(sflg[1][4]), 32'd0);
      end
      setp(0, 0, 0, 0, 0, 0);
      setp(1, 0, 0, 0, 0, 0);
      cyc();

      setp(0, 1, 1, 16'h0010, 16'hBEEF, 1);
      setp(1, 1, 0, 16'h0020, 0, 0);
      cyc();
      chk("lk_ack0_a", 32'(sflg[0][5]), 32'd1);
      chk("lk_stall_a", 32'(sflg[0][4]), 32'd0);
      setp(0, 1, 0, 16'h0010, 0, 0);
      cyc();
      chk("lk_ack0_b", 32'(sflg[0][5]), 32'd1);
      chk("lk_stall_b", 32'(sflg[0][4]), 32'd0);
      req[0] = 1'b0;
      cyc();
      chk("lk_ack1", 32'(sflg[0][4]), 32'd1);
      chk("lk_rv0", 32'(sflg[0][3]), 32'd1);
      chk("lk_beef", 32'(srd0[0]), 32'h0000BEEF);
      req[1] = 1'b0;
      cyc();

      setp(0, 1, 1, 16'h0030, 16'h1234, 1);
      setp(1, 1, 0, 16'h0031, 0, 0);
      cyc();
      chk("to_ack0", 32'(sflg[0][5]), 32'd1);
      req[0] = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         cyc();
         chk("to_ack1", 32'(sflg[0][4]), 32'(j >= 5));
         chk("to16_ack1", 32'(sflg[1][4]), 32'd0);
      end
      lk[0] = 1'b0;
      req[1] = 1'b0;
      cyc();
      cyc();

      setp(1, 1, 0, 16'h0040, 0, 0);
      cyc();
      chk("rr_ack1_pre", 32'(sflg[0][4]), 32'd1);
      rst_n = 1'b0;
      req[1] = 1'b0;
      cyc();
      chk("rst_rv1", 32'(sflg[0][2]), 32'd0);
      rst_n = 1'b1;
      setp(0, 1, 0, 16'h0041, 0, 0);
      setp(1, 1, 0, 16'h0042, 0, 0);
      cyc();
      chk("post_rst_p0", 32'(sflg[0][5]), 32'd1);
      chk("post_rst_p0_fix", 32'(sflg[1][5]), 32'd1);

      for (int n = 0; n < 800; n++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         for (int p = 0; p < 2; p++) begin
            req[p] = ($urandom_range(0, 1) != 0);
            we[p] = ($urandom_range(0, 2) == 0);
            ad[p] = 16'($urandom_range(0, 15));
            wd[p] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) lk[p] = ~lk[p];
         end
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
